// File: rtl/pwm_controller_int.sv
// Free-running PWM core with a double-buffered duty cycle, complementary outputs
// and a one-cycle end-of-period interrupt.
module pwm_controller_int #(
   parameter int period = 20
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       DutyCycle,
   output logic [1:0]        PWM_out,
   output logic              Interruput,
   output logic [period-1:0] count
);

   localparam logic [period-1:0] COUNT_ONE = {{(period-1){1'b0}}, 1'b1};

   logic [31:0] duty_q;
   logic        start_q;
   logic        count_max;
   logic [31:0] count_ext;
   logic        pwm;

   assign count_max = (count == {period{1'b1}});

   // Both sides are 32 bits so a duty of 2^period or more saturates to 100%.
   assign count_ext = {{(32-period){1'b0}}, count};
   assign pwm       = (count_ext < duty_q);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count      <= '0;
         duty_q     <= '0;
         start_q    <= 1'b1;
         Interruput <= 1'b0;
      end else begin
         count      <= count + COUNT_ONE;
         start_q    <= 1'b0;
         Interruput <= count_max;
         // The shadow only reloads at a period boundary (or the first edge after
         // reset), so a mid-period bus write never glitches the waveform.
         if (start_q || count_max) begin
            duty_q <= DutyCycle;
         end
      end
   end

   assign PWM_out = {~pwm, pwm};

endmodule

// File: tb/tb_pwm_controller_int.sv
// Scoreboard bench for pwm_controller_int at period=4: the stimulus side pushes
// expected outputs per cycle, a monitor pops and compares them.
module tb_pwm_controller_int;

   localparam int P = 4;

   logic         Clk;
   logic         Reset;
   logic [31:0]  DutyCycle;
   logic [1:0]   PWM_out;
   logic         Interruput;
   logic [P-1:0] count;

   pwm_controller_int #(.period(P)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .DutyCycle  (DutyCycle),
      .PWM_out    (PWM_out),
      .Interruput (Interruput),
      .count      (count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct packed {
      logic [P-1:0] cnt;
      logic [1:0]   pwm;
      logic         irq;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   event sample_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state of the expected behaviour
   logic [P-1:0] m_cnt;
   logic [31:0]  m_duty;
   logic         m_start;
   logic         m_irq;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   task automatic model_reset();
      m_cnt   = '0;
      m_duty  = '0;
      m_start = 1'b1;
      m_irq   = 1'b0;
   endtask

   task automatic push_expected();
      exp_t e;
      logic p0;
      p0    = (32'(m_cnt) < m_duty);
      e.cnt = m_cnt;
      e.pwm = {~p0, p0};
      e.irq = m_irq;
      sb_q.push_back(e);
   endtask

   // Model one rising edge out of reset, using the DutyCycle present at that edge.
   task automatic model_step();
      logic wrap;
      wrap = (m_cnt == 4'd15);
      if (m_start || wrap) m_duty = DutyCycle;
      m_irq   = wrap;
      m_cnt   = m_cnt + 4'd1;
      m_start = 1'b0;
      push_expected();
   endtask

   // Entered and left at a falling edge.
   task automatic run(input int n, input logic [31:0] d);
      for (int i = 0; i < n; i++) begin
         DutyCycle = d;
         @(posedge Clk);
         model_step();
         @(negedge Clk);
      end
   endtask

   // One more edge, then assert reset asynchronously between clock edges.
   task automatic edge_then_reset(input logic [31:0] d);
      DutyCycle = d;
      @(posedge Clk);
      model_step();
      #1 -> sample_ev;
      #1 Reset = 1'b0;
      model_reset();
      #1 push_expected();
      -> sample_ev;
   endtask

   task automatic hold_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         push_expected();
      end
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge Clk or sample_ev);
         while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("count", int'(count), int'(mon_e.cnt));
            chk("pwm_out", int'(PWM_out), int'(mon_e.pwm));
            chk("interrupt", int'(Interruput), int'(mon_e.irq));
            $display("t=%0t count=%0d pwm=%b irq=%b (exp %0d %b %b)", $time,
                     count, PWM_out, Interruput, mon_e.cnt, mon_e.pwm, mon_e.irq);
         end
      end
   end

   initial begin
      Reset     = 1'b0;
      DutyCycle = 32'd5;
      model_reset();
      hold_reset(2);

      run(20, 32'd5);                // first period duty 5, wrap with interrupt
      run(8, 32'd9);                 // mid-period change, still 5 this period
      run(20, 32'd9);                // new period at 9
      run(32, 32'd0);                // 0% duty
      run(20, 32'd16);               // 2^period saturates high
      run(20, 32'hFFFF_FFFF);        // no truncation of 32-bit duty
      run(20, 32'd15);               // low only at count 15
      run(34, 32'd1);                // high only at count 0

      // Reset mid-period, restart with a new duty and no interrupt on release
      for (int i = 0; i < 20 && m_cnt != 4'd9; i++) run(1, 32'd1);
      edge_then_reset(32'd1);
      DutyCycle = 32'd12;
      hold_reset(2);
      run(36, 32'd12);

      // Async reset while the interrupt pulse is high
      for (int i = 0; i < 20 && m_cnt != 4'd15; i++) run(1, 32'd12);
      edge_then_reset(32'd12);
      hold_reset(1);
      run(20, 32'd3);

      #1;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
